spi_slave_if: RTL

- Serial front end of the SPI-slave subsystem; sits directly upstream of the single-port RAM.
- Deserialises MOSI frames into ADDR_SIZE+2-bit command/data words and presents each word to the RAM with a one-cycle rx_valid strobe.
- On a read-data frame, captures the RAM's returned byte and shifts it out on MISO, MSB first.
- The SPI serial clock is the block clock, one bit per cycle.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_tx_shifter.sv | 55 +++++
 rtl/spi_slave_if.sv | 105 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-slave front end.
// The word layout is {command[1:0], payload[ADDR_SIZE-1:0]}, MSB first on the wire.
package spi_pkg;

   localparam int ADDR_SIZE_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHK_CMD,
      WRITE,
      READ_ADD,
      READ_DATA
   } state_t;

   // Command codes as the downstream RAM interprets them.
   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-in serial-out shifter for the read-data byte.
// Loads once per frame, drives MSB first, then returns MISO to 0 and raises done.
module spi_tx_shifter
   import spi_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 load_en,
   input  logic                 tx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   output logic                 miso,
   output logic                 last,
   output logic                 done
);

   localparam int CW = $clog2(ADDR_SIZE + 1);

   logic [ADDR_SIZE-1:0] shreg;
   logic [CW-1:0]        sent;
   logic                 busy;

   // High while the LSB is on MISO; the following edge completes the byte.
   assign last = busy && (sent == CW'(ADDR_SIZE));

   // NOTE: state registers use non-blocking assignments only, so every
   // flop samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         shreg <= '0;
         sent  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         miso  <= 1'b0;
      end else if (busy) begin
         if (last) begin
            miso <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
         end else begin
            miso  <= shreg[ADDR_SIZE-1];
            shreg <= {shreg[ADDR_SIZE-2:0], 1'b0};
            sent  <= sent + 1'b1;
         end
      end else if (load_en && tx_valid) begin
         miso  <= tx_data[ADDR_SIZE-1];
         shreg <= {tx_data[ADDR_SIZE-2:0], 1'b0};
         sent  <= CW'(1);
         busy  <= 1'b1;
      end
   end

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI words for the RAM and
// serialises the returned read byte on MISO. The SPI clock is clk.
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
);

   localparam int WW = ADDR_SIZE + 2;
   localparam int BW = $clog2(WW + 1);

   state_t        state;
   state_t        state_nxt;
   logic [WW-2:0] rx_shift;
   logic [BW-1:0] bit_cnt;
   logic          rd_addr_done;
   logic          tx_armed;
   logic          frame_clr;
   logic          tx_load_en;
   logic          tx_last;
   logic          tx_done;

   assign frame_clr = SS_n || (state == IDLE);

   // tx_valid only counts once the strobe has gone back low, so a level left
   // high by an earlier read can never be mistaken for this frame's data.
   assign tx_load_en = (state == READ_DATA) && tx_armed && !rx_valid && !tx_done;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt is defaulted before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if (SS_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:      state_nxt = CHK_CMD;
            CHK_CMD:   state_nxt = !MOSI ? WRITE : (rd_addr_done ? READ_DATA : READ_ADD);
            WRITE,
            READ_ADD,
            READ_DATA: state_nxt = state;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_shift     <= '0;
         bit_cnt      <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_done <= 1'b0;
         tx_armed     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (frame_clr) begin
            rx_shift <= '0;
            bit_cnt  <= '0;
            tx_armed <= 1'b0;
         end else if (bit_cnt < BW'(WW)) begin
            rx_shift <= {rx_shift[WW-3:0], MOSI};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(WW - 1)) begin
               rx_data  <= {rx_shift, MOSI};
               rx_valid <= 1'b1;
               if (state == READ_ADD)  rd_addr_done <= 1'b1;
               if (state == READ_DATA) tx_armed     <= 1'b1;
            end
         end
         // A byte whose LSB has been driven counts as delivered even if SS_n rises now.
         if (tx_last) rd_addr_done <= 1'b0;
      end
   end

   spi_tx_shifter #(
      .ADDR_SIZE(ADDR_SIZE)
   ) u_tx (
      .clk     (clk),
      .rst     (rst),
      .clear   (frame_clr),
      .load_en (tx_load_en),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .miso    (MISO),
      .last    (tx_last),
      .done    (tx_done)
   );

endmodule
